// File: rtl/morse_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_symbol_decoder
// Description : Collects SHORT (dot) / LONG (dash) element pulses into a
//               length-tracked shift register and, on END_CHAR, decodes the
//               (length, pattern) pair into a character code:
//               A..Z = 1..26, digits 0..9 = 27..36 (when enabled).
//               Invalid, conflicting or over-length symbols report ERROR.
// Ports       : Clk      - system clock, rising edge
//               RESET    - asynchronous active-high reset
//               SHORT    - one-cycle dot pulse
//               LONG     - one-cycle dash pulse
//               END_CHAR - one-cycle end-of-symbol pulse
//               LETTER   - registered decoded code, held between strobes
//               STROBE   - one-cycle pulse when LETTER/ERROR update
//               ERROR    - registered error flag, held between strobes
//               BUSY     - high while a symbol is partially collected
// Revision    : 1.0 - initial release
// ============================================================================
module morse_symbol_decoder #(
    parameter int MAX_LEN       = 6,
    parameter int ENABLE_DIGITS = 1,
    parameter int CODE_W        = 6
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              SHORT,
    input  logic              LONG,
    input  logic              END_CHAR,
    output logic [CODE_W-1:0] LETTER,
    output logic              STROBE,
    output logic              ERROR,
    output logic              BUSY
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [LEN_W-1:0] c_LEN_FULL = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_COLLECT = 1'b1;

    logic [0:0]         r_state;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_pat;
    logic               r_bad;
    logic [CODE_W-1:0]  r_letter;
    logic               r_strobe;
    logic               r_error;
    logic               r_busy;

    logic               w_elem;
    logic [LEN_W-1:0]   w_n_len;
    logic [MAX_LEN-1:0] w_n_pat;
    logic               w_n_bad;
    logic               w_fire;
    logic               w_hi_zero;
    logic [5:0]         w_code;
    logic               w_err;

    // Table lookup keyed on (length, low five pattern bits). The first
    // element received sits in the most significant of the low `l` bits.
    // A return of 0 means "no such symbol".
    function automatic logic [5:0] f_decode(input logic [LEN_W-1:0] l,
                                            input logic [4:0]       p);
        logic [5:0] c;
        c = 6'd0;
        if (l == LEN_W'(1)) begin
            case (p)
                5'b00000: c = 6'd5;   // E .
                5'b00001: c = 6'd20;  // T -
                default:  c = 6'd0;
            endcase
        end else if (l == LEN_W'(2)) begin
            case (p)
                5'b00001: c = 6'd1;   // A .-
                5'b00000: c = 6'd9;   // I ..
                5'b00011: c = 6'd13;  // M --
                5'b00010: c = 6'd14;  // N -.
                default:  c = 6'd0;
            endcase
        end else if (l == LEN_W'(3)) begin
            case (p)
                5'b00100: c = 6'd4;   // D -..
                5'b00110: c = 6'd7;   // G --.
                5'b00101: c = 6'd11;  // K -.-
                5'b00111: c = 6'd15;  // O ---
                5'b00010: c = 6'd18;  // R .-.
                5'b00000: c = 6'd19;  // S ...
                5'b00001: c = 6'd21;  // U ..-
                5'b00011: c = 6'd23;  // W .--
                default:  c = 6'd0;
            endcase
        end else if (l == LEN_W'(4)) begin
            case (p)
                5'b01000: c = 6'd2;   // B -...
                5'b01010: c = 6'd3;   // C -.-.
                5'b00010: c = 6'd6;   // F ..-.
                5'b00000: c = 6'd8;   // H ....
                5'b00111: c = 6'd10;  // J .---
                5'b00100: c = 6'd12;  // L .-..
                5'b00110: c = 6'd16;  // P .--.
                5'b01101: c = 6'd17;  // Q --.-
                5'b00001: c = 6'd22;  // V ...-
                5'b01001: c = 6'd24;  // X -..-
                5'b01011: c = 6'd25;  // Y -.--
                5'b01100: c = 6'd26;  // Z --..
                default:  c = 6'd0;
            endcase
        end else if ((l == LEN_W'(5)) && (ENABLE_DIGITS != 0)) begin
            case (p)
                5'b11111: c = 6'd27;  // 0 -----
                5'b01111: c = 6'd28;  // 1 .----
                5'b00111: c = 6'd29;  // 2 ..---
                5'b00011: c = 6'd30;  // 3 ...--
                5'b00001: c = 6'd31;  // 4 ....-
                5'b00000: c = 6'd32;  // 5 .....
                5'b10000: c = 6'd33;  // 6 -....
                5'b11000: c = 6'd34;  // 7 --...
                5'b11100: c = 6'd35;  // 8 ---..
                5'b11110: c = 6'd36;  // 9 ----.
                default:  c = 6'd0;
            endcase
        end
        return c;
    endfunction

    // Element acceptance: the symbol state after including any element
    // arriving this cycle. A simultaneous SHORT and LONG stores a dash and
    // poisons the symbol; an element beyond capacity poisons it unshifted.
    always_comb begin
        w_elem  = SHORT | LONG;
        w_n_len = r_len;
        w_n_pat = r_pat;
        w_n_bad = r_bad | (SHORT & LONG);
        if (w_elem) begin
            if (r_len == c_LEN_FULL) begin
                w_n_bad = 1'b1;
            end else begin
                w_n_pat = {r_pat[MAX_LEN-2:0], LONG};
                w_n_len = r_len + c_LEN_ONE;
            end
        end
    end

    // Pattern bits above position 4 can only be set by symbols longer than
    // five elements, which never decode; treat them as an extra guard.
    generate
        if (MAX_LEN > 5) begin : g_hi_bits
            assign w_hi_zero = ~|w_n_pat[MAX_LEN-1:5];
        end else begin : g_no_hi_bits
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    assign w_code = f_decode(w_n_len, w_n_pat[4:0]);
    assign w_err  = w_n_bad | ~w_hi_zero | (w_code == 6'd0);

    // END_CHAR alone in IDLE carries no symbol and is ignored.
    assign w_fire = END_CHAR & ((r_state == c_ST_COLLECT) | w_elem);

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_state  <= c_ST_IDLE;
            r_len    <= '0;
            r_pat    <= '0;
            r_bad    <= 1'b0;
            r_letter <= '0;
            r_strobe <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_fire) begin
                r_strobe <= 1'b1;
                r_error  <= w_err;
                r_letter <= w_err ? '0 : CODE_W'(w_code);
                r_state  <= c_ST_IDLE;
                r_len    <= '0;
                r_pat    <= '0;
                r_bad    <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                r_len  <= w_n_len;
                r_pat  <= w_n_pat;
                r_bad  <= w_n_bad;
                r_busy <= (w_n_len != '0) | w_n_bad;
                if (w_elem) begin
                    r_state <= c_ST_COLLECT;
                end
            end
        end
    end

    assign LETTER = r_letter;
    assign STROBE = r_strobe;
    assign ERROR  = r_error;
    assign BUSY   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_symbol_decoder
// Description : Directed bench for morse_symbol_decoder. One instance with
//               digits enabled and one with digits disabled share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_decoder;

    logic       Clk;
    logic       RESET;
    logic       SHORT;
    logic       LONG;
    logic       END_CHAR;
    logic [5:0] letter_d;
    logic       strobe_d;
    logic       error_d;
    logic       busy_d;
    logic [5:0] letter_n;
    logic       strobe_n;
    logic       error_n;
    logic       busy_n;

    int checks;
    int errors;

    morse_symbol_decoder #(
        .MAX_LEN      (6),
        .ENABLE_DIGITS(1),
        .CODE_W       (6)
    ) dut (
        .Clk     (Clk),
        .RESET   (RESET),
        .SHORT   (SHORT),
        .LONG    (LONG),
        .END_CHAR(END_CHAR),
        .LETTER  (letter_d),
        .STROBE  (strobe_d),
        .ERROR   (error_d),
        .BUSY    (busy_d)
    );

    morse_symbol_decoder #(
        .MAX_LEN      (6),
        .ENABLE_DIGITS(0),
        .CODE_W       (6)
    ) dut_nd (
        .Clk     (Clk),
        .RESET   (RESET),
        .SHORT   (SHORT),
        .LONG    (LONG),
        .END_CHAR(END_CHAR),
        .LETTER  (letter_n),
        .STROBE  (strobe_n),
        .ERROR   (error_n),
        .BUSY    (busy_n)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one clock edge, then clear them; returns 1 ns
    // after the edge so registered outputs of that edge are visible.
    task automatic cyc(input logic s, input logic l, input logic e);
        SHORT    = s;
        LONG     = l;
        END_CHAR = e;
        @(posedge Clk);
        #1;
        SHORT    = 1'b0;
        LONG     = 1'b0;
        END_CHAR = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        RESET    = 1'b1;
        SHORT    = 1'b0;
        LONG     = 1'b0;
        END_CHAR = 1'b0;
        #1;
        chk("rst_letter", 32'(letter_d), 32'd0);
        chk("rst_strobe", 32'(strobe_d), 32'd0);
        chk("rst_error",  32'(error_d),  32'd0);
        chk("rst_busy",   32'(busy_d),   32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        RESET = 1'b0;

        // A: . - then END_CHAR on its own cycle
        cyc(1'b1, 1'b0, 1'b0);
        chk("a_busy1",   32'(busy_d),   32'd1);
        chk("a_nostb",   32'(strobe_d), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("a_strobe",  32'(strobe_d), 32'd1);
        chk("a_letter",  32'(letter_d), 32'd1);
        chk("a_error",   32'(error_d),  32'd0);
        chk("a_busy0",   32'(busy_d),   32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a_stb_low", 32'(strobe_d), 32'd0);
        chk("a_hold",    32'(letter_d), 32'd1);

        // Q: - - . with the final - arriving alongside END_CHAR
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("q_strobe",  32'(strobe_d), 32'd1);
        chk("q_letter",  32'(letter_d), 32'd17);
        chk("q_error",   32'(error_d),  32'd0);
        chk("q_nd_let",  32'(letter_n), 32'd17);

        // T: single element together with END_CHAR straight from IDLE
        cyc(1'b0, 1'b1, 1'b1);
        chk("t_strobe",  32'(strobe_d), 32'd1);
        chk("t_letter",  32'(letter_d), 32'd20);

        // Digit 0: five dashes, then END_CHAR
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("d0_letter", 32'(letter_d), 32'd27);
        chk("d0_error",  32'(error_d),  32'd0);
        chk("d0_nd_let", 32'(letter_n), 32'd0);
        chk("d0_nd_err", 32'(error_n),  32'd1);
        chk("d0_nd_stb", 32'(strobe_n), 32'd1);

        // Over-length: seven dots with capacity six
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("ol_busy",   32'(busy_d),   32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ol_strobe", 32'(strobe_d), 32'd1);
        chk("ol_error",  32'(error_d),  32'd1);
        chk("ol_letter", 32'(letter_d), 32'd0);

        // Unassigned four-element pattern .-.-
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("un_error",  32'(error_d),  32'd1);
        chk("un_letter", 32'(letter_d), 32'd0);

        // Conflict: SHORT and LONG together, then a dot
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("cf_error",  32'(error_d),  32'd1);
        chk("cf_letter", 32'(letter_d), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("cf_e_let",  32'(letter_d), 32'd5);
        chk("cf_e_err",  32'(error_d),  32'd0);

        // END_CHAR while idle must do nothing
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ie_strobe", 32'(strobe_d), 32'd0);
        chk("ie_letter", 32'(letter_d), 32'd5);
        chk("ie_error",  32'(error_d),  32'd0);
        chk("ie_busy",   32'(busy_d),   32'd0);

        // Asynchronous reset in the middle of a symbol
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ar_busy1",  32'(busy_d),   32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_letter", 32'(letter_d), 32'd0);
        chk("ar_busy0",  32'(busy_d),   32'd0);
        chk("ar_strobe", 32'(strobe_d), 32'd0);
        @(posedge Clk);
        #1;
        RESET = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk("ar_nostb",  32'(strobe_d), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ar_e_stb",  32'(strobe_d), 32'd1);
        chk("ar_e_let",  32'(letter_d), 32'd5);
        chk("ar_e_err",  32'(error_d),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_symbol_decoder.md
Name: morse_symbol_decoder

Overview:
- Parametrised successor to the fixed 5-bit letter tree decoder.
- Accumulates SHORT/LONG elements into a length-tracked shift register and decodes on END_CHAR using a (length, pattern) lookup.
- Supports A-Z plus optional digits 0-9, and flags invalid or over-length symbols.
- Returns to idle on its own after every strobe. Sits between the element classifier (SHORT/LONG/END_CHAR pulses) and the character/display logic.

Parameters:
- MAX_LEN, 6: element capacity of the pattern register; must be >= 5. Symbols longer than 5 elements never decode to a valid code.
- ENABLE_DIGITS, 1: 1 = decode 5-element digit patterns, 0 = digit patterns report ERROR.
- CODE_W, 6: LETTER width; must be >= 6 if ENABLE_DIGITS = 1, else >= 5.

Ports:
- Clk  in  1  system clock; all state changes on posedge
- RESET  in  1  asynchronous, active-high reset
- SHORT  in  1  one-cycle pulse: dot element
- LONG  in  1  one-cycle pulse: dash element
- END_CHAR  in  1  one-cycle pulse: current symbol complete
- LETTER  out  CODE_W  registered decoded code; held until the next strobe
- STROBE  out  1  one-cycle pulse: LETTER/ERROR updated
- ERROR  out  1  registered; valid with STROBE, held until the next strobe
- BUSY  out  1  1 while at least one element has been accepted in the current symbol

Behaviour:
- Reset (async, RESET=1): LETTER=0, STROBE=0, ERROR=0, BUSY=0, len=0, pattern=0, bad=0, state=IDLE. Asserting RESET mid-symbol discards the partial symbol; no strobe is issued.
- Element encoding: dot=0, dash=1. Accepted element is shifted in: pattern <= {pattern[MAX_LEN-2:0], bit}. The first element ends up as the most significant of the low `len` bits.
- Conflict: SHORT & LONG in the same cycle sets sticky `bad`. len still increments; bit stored is 1.
- Counter: len saturates at MAX_LEN. An element arriving with len == MAX_LEN sets `bad`; the pattern is not shifted.
- States:
  - IDLE: len=0. An element moves to COLLECT.
  - COLLECT: accepts elements. END_CHAR causes decode, then return to IDLE.
  - There is no terminal DONE state.
- END_CHAR decode:
  - Any element pulse in the same cycle as END_CHAR is appended first, then the symbol is decoded (final element).
  - Results are registered on that edge: STROBE=1 for exactly one cycle, then len=0, pattern=0, bad=0, state=IDLE.
  - New elements are accepted on the very next cycle.
- END_CHAR in IDLE with no element in the same cycle: ignored. No strobe, outputs unchanged.
- Decode table, valid only if bad=0:
  - Letters, len 1-4 with standard International Morse patterns: A=1 … Z=26. Examples: E (len1, 0)=5; T (len1, 1)=20; A (len2, 01)=1; Q (len4, 1101)=17.
  - Digits, len 5, only if ENABLE_DIGITS: 0=27 ("-----"), 1=28 (".----"), … 9=36 ("----.").
  - Anything else, or bad=1: LETTER=0, ERROR=1.
  - Valid decode: ERROR=0.
- Latency: STROBE/LETTER/ERROR are valid in the cycle after the edge that samples END_CHAR (1 clock).
- LETTER and ERROR hold between strobes; STROBE is never high for 2 consecutive cycles.
- BUSY = (len != 0) or bad, registered. It is cleared on the same edge that raises STROBE.

Test Plan:
- SHORT, LONG, END_CHAR on separate cycles -> STROBE pulse one cycle after END_CHAR, LETTER=1 (A), ERROR=0, BUSY then 0.
- LONG,LONG,SHORT,LONG then END_CHAR together with a final pulse; also LONG ×5 + END_CHAR -> first: LETTER=17 (Q, final element appended); second: LETTER=27 (digit 0, ENABLE_DIGITS=1). Rerun second with ENABLE_DIGITS=0 -> LETTER=0, ERROR=1.
- Over-length and invalid symbols -> 7 SHORTs (MAX_LEN=6) + END_CHAR gives ERROR=1, LETTER=0; ".-.-" (len4, 0101) + END_CHAR gives ERROR=1 (unassigned pattern).
- SHORT&LONG asserted same cycle, SHORT, END_CHAR -> ERROR=1, LETTER=0. A following SHORT, END_CHAR -> LETTER=5, ERROR=0 (bad cleared).
- END_CHAR in IDLE -> no STROBE, LETTER/ERROR unchanged from the previous symbol.
- LONG, SHORT, then RESET asserted mid-cycle (async) -> all outputs 0 immediately, no STROBE. After release, SHORT, END_CHAR -> LETTER=5.
